pong_match_controller: RTL and testbench

PONG_MATCH_CONTROLLER -- requirements
Module: pong_match_controller

---
 rtl/pong_match_controller.sv | 141 ++++++++++++++
 tb/tb_pong_match_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pong_match_controller.sv
// pong_match_controller: debounced start/pause key plus IDLE/SERVE/PLAY/PAUSE/OVER match sequencing.
`ifndef PLAYER_1_COLOR
`define PLAYER_1_COLOR 3'b100
`endif
`ifndef PLAYER_2_COLOR
`define PLAYER_2_COLOR 3'b001
`endif
module pong_match_controller #(
   parameter int WIN_SCORE       = 7,
   parameter int SERVE_FRAMES    = 60,
   parameter int OVER_FRAMES     = 180,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic       CLOCK_25,
   input  logic       RESET,
   input  logic       frame_tick,
   input  logic       key0,
   input  logic       miss_1,
   input  logic       miss_2,
   output logic       run,
   output logic       serve_req,
   output logic       serve_side,
   output logic [2:0] score_1,
   output logic [2:0] score_2,
   output logic [2:0] state,
   output logic [2:0] winner_color
);
   localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, PAUSE = 3'd3, OVER = 3'd4;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0] sync_q, sync_d;
   logic db_q, db_d, db_done, press, key_s, won;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic [2:0] state_q, state_d, ret_q, ret_d, score_1_q, score_1_d, score_2_q, score_2_d, winner_q, winner_d;
   logic [2:0] s1_inc, s2_inc;
   logic [7:0] frame_q, frame_d, frame_inc;
   logic side_q, side_d, serve_req_q, serve_req_d;
   // debounced level starts "released"; a press is the high-to-low flip of that level
   always_comb begin
      sync_d   = {sync_q[0], key0};
      key_s    = sync_q[1];
      db_done  = db_cnt_q == DW'(DEBOUNCE_CYCLES - 1);
      db_d     = (key_s != db_q && db_done) ? key_s : db_q;
      db_cnt_d = (key_s == db_q || db_done) ? '0 : db_cnt_q + 1'b1;
      press    = db_q & ~key_s & db_done;
   end
   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      frame_d     = frame_q;
      score_1_d   = score_1_q;
      score_2_d   = score_2_q;
      winner_d    = winner_q;
      side_d      = side_q;
      serve_req_d = 1'b0;
      won         = 1'b0;
      frame_inc   = frame_q + 8'd1;
      s1_inc      = score_1_q + 3'd1;
      s2_inc      = score_2_q + 3'd1;
      case (state_q)
         IDLE: if (press) begin
            state_d     = SERVE;
            score_1_d   = '0;
            score_2_d   = '0;
            winner_d    = '0;
            side_d      = 1'b0;
            frame_d     = '0;
            serve_req_d = 1'b1;
         end
         SERVE: if (press) begin
            ret_d   = SERVE;
            state_d = PAUSE;
         end else if (frame_tick) begin
            frame_d = frame_inc == 8'(SERVE_FRAMES) ? 8'd0 : frame_inc;
            state_d = frame_inc == 8'(SERVE_FRAMES) ? PLAY : SERVE;
         end
         PLAY: if (miss_1 || miss_2) begin
            // miss_1 has priority; a press in the same cycle is dropped
            if (miss_1) begin
               score_2_d = s2_inc;
               side_d    = 1'b0;
               won       = s2_inc == 3'(WIN_SCORE);
               winner_d  = won ? `PLAYER_2_COLOR : winner_q;
            end else begin
               score_1_d = s1_inc;
               side_d    = 1'b1;
               won       = s1_inc == 3'(WIN_SCORE);
               winner_d  = won ? `PLAYER_1_COLOR : winner_q;
            end
            frame_d     = '0;
            state_d     = won ? OVER : SERVE;
            serve_req_d = ~won;
         end else if (press) begin
            ret_d   = PLAY;
            state_d = PAUSE;
         end
         PAUSE: state_d = press ? ret_q : PAUSE;
         OVER: if (press) begin
            state_d = IDLE;
            frame_d = '0;
         end else if (frame_tick) begin
            frame_d = frame_inc == 8'(OVER_FRAMES) ? 8'd0 : frame_inc;
            state_d = frame_inc == 8'(OVER_FRAMES) ? IDLE : OVER;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLOCK_25 or posedge RESET) begin
      if (RESET) begin
         sync_q      <= 2'b11;
         db_q        <= 1'b1;
         db_cnt_q    <= '0;
         state_q     <= IDLE;
         ret_q       <= IDLE;
         frame_q     <= '0;
         score_1_q   <= '0;
         score_2_q   <= '0;
         winner_q    <= '0;
         side_q      <= 1'b0;
         serve_req_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         db_q        <= db_d;
         db_cnt_q    <= db_cnt_d;
         state_q     <= state_d;
         ret_q       <= ret_d;
         frame_q     <= frame_d;
         score_1_q   <= score_1_d;
         score_2_q   <= score_2_d;
         winner_q    <= winner_d;
         side_q      <= side_d;
         serve_req_q <= serve_req_d;
      end
   end
   assign run          = state_q == PLAY;
   assign serve_req    = serve_req_q;
   assign serve_side   = side_q;
   assign score_1      = score_1_q;
   assign score_2      = score_2_q;
   assign state        = state_q;
   assign winner_color = winner_q;
endmodule

// File: tb/tb_pong_match_controller.sv
// tb_pong_match_controller: event-level reference model of the match rules checked against the DUT.
`ifndef PLAYER_1_COLOR
`define PLAYER_1_COLOR 3'b100
`endif
`ifndef PLAYER_2_COLOR
`define PLAYER_2_COLOR 3'b001
`endif
module tb_pong_match_controller;
   localparam int W = 7, SF = 60, OF = 180, DB = 16;
   logic CLOCK_25 = 0, RESET = 1, frame_tick = 0, key0 = 1, miss_1 = 0, miss_2 = 0;
   logic run, serve_req, serve_side;
   logic [2:0] score_1, score_2, state, winner_color;
   int total = 0, bad = 0, sr_cnt = 0, m_sr = 0, m_fr = 0;
   logic [2:0] m_st = 0, m_ret = 0, m_s1 = 0, m_s2 = 0, m_win = 0;
   logic m_side = 0;
   wire [13:0] obs = {state, run, serve_side, score_1, score_2, winner_color};

   pong_match_controller #(.WIN_SCORE(W), .SERVE_FRAMES(SF), .OVER_FRAMES(OF), .DEBOUNCE_CYCLES(DB)) dut (
      .CLOCK_25(CLOCK_25), .RESET(RESET), .frame_tick(frame_tick), .key0(key0),
      .miss_1(miss_1), .miss_2(miss_2), .run(run), .serve_req(serve_req), .serve_side(serve_side),
      .score_1(score_1), .score_2(score_2), .state(state), .winner_color(winner_color));

   always #5 CLOCK_25 = ~CLOCK_25;
   always @(posedge CLOCK_25) if (serve_req) sr_cnt <= sr_cnt + 1;

   function automatic logic [13:0] exp_vec();
      return {m_st, m_st == 3'd2, m_side, m_s1, m_s2, m_win};
   endfunction

   // model: the match as a sequence of discrete events
   task automatic m_reset();
      m_st = 0; m_ret = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_side = 0; m_fr = 0;
   endtask
   task automatic m_tick();
      if (m_st == 1 || m_st == 4) begin
         m_fr++;
         if (m_st == 1 && m_fr == SF) begin m_st = 2; m_fr = 0; end
         if (m_st == 4 && m_fr == OF) begin m_st = 0; m_fr = 0; end
      end
   endtask
   task automatic m_miss(input bit a, input bit b);
      if (m_st != 2 || !(a || b)) return;
      if (a) begin m_s2++; m_side = 0; end
      else begin m_s1++; m_side = 1; end
      m_fr = 0;
      if (a && m_s2 == W) begin m_st = 4; m_win = `PLAYER_2_COLOR; end
      else if (!a && m_s1 == W) begin m_st = 4; m_win = `PLAYER_1_COLOR; end
      else begin m_st = 1; m_sr++; end
   endtask
   task automatic m_press();
      if (m_st == 0) begin
         m_st = 1; m_s1 = 0; m_s2 = 0; m_win = 0; m_side = 0; m_fr = 0; m_sr++;
      end else if (m_st == 1 || m_st == 2) begin m_ret = m_st; m_st = 3; end
      else if (m_st == 3) m_st = m_ret;
      else begin m_st = 0; m_fr = 0; end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin @(posedge CLOCK_25); #1; end
   endtask
   task automatic tick();
      frame_tick = 1; cyc(); frame_tick = 0; cyc(); m_tick();
   endtask
   task automatic miss(input bit a, input bit b);
      miss_1 = a; miss_2 = b; cyc(); miss_1 = 0; miss_2 = 0; cyc(); m_miss(a, b);
   endtask
   task automatic press(input int hold = DB + 4);
      key0 = 0; cyc(hold); key0 = 1; cyc(DB + 4); m_press();
   endtask

   task automatic test_reset();
      cyc(3);
      total++; if (obs !== 14'd0) begin bad++; $display("FAIL reset_held obs=%h exp=0", obs); end
      RESET = 0; cyc(3);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL reset_release obs=%h exp=%h", obs, exp_vec()); end
      total++; if (sr_cnt !== 0) begin bad++; $display("FAIL reset_serve_req got=%0d exp=0", sr_cnt); end
   endtask

   task automatic test_start();
      press(5 * DB);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL start_held obs=%h exp=%h", obs, exp_vec()); end
      total++; if (sr_cnt !== m_sr) begin bad++; $display("FAIL start_serve_req got=%0d exp=%0d", sr_cnt, m_sr); end
      repeat (SF - 1) tick();
      total++; if (obs !== exp_vec() || state !== 3'd1) begin bad++; $display("FAIL serve_59 obs=%h exp=%h", obs, exp_vec()); end
      tick();
      total++; if (obs !== exp_vec() || run !== 1'b1) begin bad++; $display("FAIL serve_to_play obs=%h exp=%h", obs, exp_vec()); end
   endtask

   task automatic test_miss();
      miss(1, 0);
      total++; if (obs !== exp_vec() || score_2 !== 3'd1) begin bad++; $display("FAIL miss1 obs=%h exp=%h", obs, exp_vec()); end
      total++; if (sr_cnt !== m_sr) begin bad++; $display("FAIL miss1_serve_req got=%0d exp=%0d", sr_cnt, m_sr); end
      miss(0, 1);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL miss_in_serve obs=%h exp=%h", obs, exp_vec()); end
   endtask

   task automatic test_pause();
      repeat (SF) tick();
      press();
      total++; if (obs !== exp_vec() || state !== 3'd3) begin bad++; $display("FAIL pause_enter obs=%h exp=%h", obs, exp_vec()); end
      repeat (100) tick();
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL pause_ticks obs=%h exp=%h", obs, exp_vec()); end
      press();
      total++; if (obs !== exp_vec() || run !== 1'b1) begin bad++; $display("FAIL pause_resume obs=%h exp=%h", obs, exp_vec()); end
      total++; if (sr_cnt !== m_sr) begin bad++; $display("FAIL resume_serve_req got=%0d exp=%0d", sr_cnt, m_sr); end
   endtask

   task automatic test_simultaneous_and_bounce();
      miss(1, 1);
      total++; if (obs !== exp_vec() || score_2 !== 3'd2) begin bad++; $display("FAIL both_miss obs=%h exp=%h", obs, exp_vec()); end
      repeat (5) begin key0 = 0; cyc(DB - 4); key0 = 1; cyc(3); end
      cyc(DB + 4);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL bounce obs=%h exp=%h", obs, exp_vec()); end
      repeat (10) tick();
      press();
      repeat (5) tick();
      press();
      repeat (SF - 11) tick();
      total++; if (obs !== exp_vec() || state !== 3'd1) begin bad++; $display("FAIL serve_frozen obs=%h exp=%h", obs, exp_vec()); end
      tick();
      total++; if (obs !== exp_vec() || state !== 3'd2) begin bad++; $display("FAIL serve_resumed obs=%h exp=%h", obs, exp_vec()); end
   endtask

   task automatic test_win();
      for (int r = 0; r < 12 && m_st != 4; r++) begin
         for (int t = 0; t < SF && m_st != 2; t++) tick();
         miss(0, 1);
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL win_round%0d obs=%h exp=%h", r, obs, exp_vec()); end
      end
      total++; if (state !== 3'd4 || winner_color !== `PLAYER_1_COLOR || score_1 !== 3'd7 || run !== 1'b0) begin
         bad++; $display("FAIL win_over state=%0d winner=%b s1=%0d exp state=4 winner=%b s1=7", state, winner_color, score_1, `PLAYER_1_COLOR);
      end
      repeat (OF - 1) tick();
      total++; if (obs !== exp_vec() || state !== 3'd4) begin bad++; $display("FAIL over_179 obs=%h exp=%h", obs, exp_vec()); end
      tick();
      total++; if (obs !== exp_vec() || state !== 3'd0) begin bad++; $display("FAIL over_to_idle obs=%h exp=%h", obs, exp_vec()); end
   endtask

   task automatic test_random();
      press();
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(99);
         if (r < 70) tick();
         else if (r < 95) miss(1'($urandom_range(1)), 1'($urandom_range(1)));
         else press();
         total++; if (obs !== exp_vec() || sr_cnt !== m_sr) begin
            bad++; $display("FAIL random%0d obs=%h exp=%h sr=%0d exp_sr=%0d", i, obs, exp_vec(), sr_cnt, m_sr);
         end
      end
   endtask

   task automatic test_reset_mid();
      if (m_st != 2) begin
         if (m_st != 1) begin
            if (m_st == 3 || m_st == 4) press();
            if (m_st == 0) press();
            if (m_st == 3) press();
         end
         for (int t = 0; t < SF && m_st == 1; t++) tick();
      end
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL pre_abort obs=%h exp=%h", obs, exp_vec()); end
      RESET = 1; #2;
      total++; if (obs !== 14'd0 || serve_req !== 1'b0) begin bad++; $display("FAIL abort obs=%h exp=0", obs); end
      cyc(3); RESET = 0; cyc(5); m_reset();
      total++; if (obs !== exp_vec() || sr_cnt !== m_sr) begin bad++; $display("FAIL abort_release obs=%h sr=%0d exp_sr=%0d", obs, sr_cnt, m_sr); end
      press();
      total++; if (obs !== exp_vec() || sr_cnt !== m_sr) begin bad++; $display("FAIL restart obs=%h exp=%h", obs, exp_vec()); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_miss();
      test_pause();
      test_simultaneous_and_bounce();
      test_win();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
